// File: rtl/rob_multi_commit.sv
// Reorder buffer: one allocation, WB_PORTS tag-addressed writebacks and up to COMMIT_W
// in-order retirements per cycle. Define ROB_EXC_EN to add precise-exception handling.
module rob_multi_commit #(
    parameter int unsigned  DEPTH    = 16,
    parameter int unsigned  DATA_W   = 32,
    parameter int unsigned  AREG_W   = 6,
    parameter int unsigned  WB_PORTS = 2,
    parameter int unsigned  COMMIT_W = 2,
    localparam int unsigned TAG_W    = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         alloc_valid,
    input  logic [AREG_W-1:0]            alloc_dest_reg,
    output logic                         alloc_ready,
    output logic [TAG_W-1:0]             alloc_tag,
    input  logic [WB_PORTS-1:0]          wb_valid,
    input  logic [WB_PORTS*TAG_W-1:0]    wb_tag,
    input  logic [WB_PORTS*DATA_W-1:0]   wb_value,
`ifdef ROB_EXC_EN
    input  logic [WB_PORTS-1:0]          wb_exc,
    output logic                         exc_valid,
    output logic [TAG_W-1:0]             exc_tag,
`endif
    input  logic                         commit_en,
    input  logic                         flush,
    output logic [COMMIT_W-1:0]          commit_valid,
    output logic [COMMIT_W*AREG_W-1:0]   commit_reg,
    output logic [COMMIT_W*DATA_W-1:0]   commit_value,
    output logic [TAG_W:0]               count,
    output logic                         empty,
    output logic                         full
);
    localparam int unsigned CNT_W = TAG_W + 1;
    localparam int unsigned K_W   = $clog2(COMMIT_W + 1);

    logic [DEPTH-1:0]           valid_q, valid_d, ready_q, ready_d, exc_view;
    logic [AREG_W-1:0]          dest_q  [DEPTH];
    logic [AREG_W-1:0]          dest_d  [DEPTH];
    logic [DATA_W-1:0]          value_q [DEPTH];
    logic [DATA_W-1:0]          value_d [DEPTH];
    logic [TAG_W-1:0]           head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]           count_q, count_d;
    logic [COMMIT_W-1:0]        commit_valid_q, commit_valid_d;
    logic [COMMIT_W*AREG_W-1:0] commit_reg_q, commit_reg_d;
    logic [COMMIT_W*DATA_W-1:0] commit_value_q, commit_value_d;
    logic                       exc_valid_d;
    logic [TAG_W-1:0]           exc_tag_d;
    logic                       alloc_accept, exc_hit, run;
    logic [COMMIT_W-1:0]        take;
    logic [K_W-1:0]             k;
    logic [TAG_W-1:0]           idx, cidx, wtag;

`ifdef ROB_EXC_EN
    logic [DEPTH-1:0] exc_q, exc_d;
    logic             exc_valid_q;
    logic [TAG_W-1:0] exc_tag_q;

    assign exc_view  = exc_q;
    assign exc_valid = exc_valid_q;
    assign exc_tag   = exc_tag_q;
`else
    assign exc_view  = '0;
`endif

    assign alloc_ready  = (count_q != CNT_W'(DEPTH));
    assign alloc_accept = alloc_valid && alloc_ready;
    assign alloc_tag    = tail_q;
    assign count        = count_q;
    assign empty        = (count_q == '0);
    assign full         = (count_q == CNT_W'(DEPTH));
    assign commit_valid = commit_valid_q;
    assign commit_reg   = commit_reg_q;
    assign commit_value = commit_value_q;

    // Retire mask: contiguous run of valid, ready, non-excepting slots starting at head
    always_comb begin
        take    = '0;
        k       = '0;
        run     = commit_en;
        idx     = '0;
        exc_hit = commit_en && (count_q != '0) && valid_q[head_q] && ready_q[head_q]
                  && exc_view[head_q];
        for (int s = 0; s < int'(COMMIT_W); s++) begin
            idx = head_q + TAG_W'(s);
            if (run && (CNT_W'(s) < count_q) && valid_q[idx] && ready_q[idx] && !exc_view[idx]) begin
                take[s] = 1'b1;
                k       = k + K_W'(1);
            end else begin
                run = 1'b0;
            end
        end
    end

    // Next state: flush (external or exception) overrides everything else
    always_comb begin
        valid_d        = valid_q;
        ready_d        = ready_q;
        dest_d         = dest_q;
        value_d        = value_q;
        head_d         = head_q;
        tail_d         = tail_q;
        count_d        = count_q;
        commit_valid_d = '0;
        commit_reg_d   = '0;
        commit_value_d = '0;
        exc_valid_d    = 1'b0;
        exc_tag_d      = '0;
        cidx           = '0;
        wtag           = '0;
`ifdef ROB_EXC_EN
        exc_d          = exc_q;
`endif
        if (flush || exc_hit) begin
            valid_d     = '0;
            ready_d     = '0;
            head_d      = '0;
            tail_d      = '0;
            count_d     = '0;
            exc_valid_d = !flush;
            exc_tag_d   = flush ? '0 : head_q;
        end else begin
            // Later ports overwrite earlier ones on a shared tag
            for (int p = 0; p < int'(WB_PORTS); p++) begin
                wtag = wb_tag[p*TAG_W +: TAG_W];
                if (wb_valid[p] && valid_q[wtag]) begin
                    ready_d[wtag] = 1'b1;
                    value_d[wtag] = wb_value[p*DATA_W +: DATA_W];
`ifdef ROB_EXC_EN
                    exc_d[wtag]   = wb_exc[p];
`endif
                end
            end
            for (int s = 0; s < int'(COMMIT_W); s++) begin
                if (take[s]) begin
                    cidx                                = head_q + TAG_W'(s);
                    valid_d[cidx]                       = 1'b0;
                    ready_d[cidx]                       = 1'b0;
                    commit_valid_d[s]                   = 1'b1;
                    commit_reg_d[s*AREG_W +: AREG_W]    = dest_q[cidx];
                    commit_value_d[s*DATA_W +: DATA_W]  = value_q[cidx];
                end
            end
            head_d = head_q + TAG_W'(k);
            if (alloc_accept) begin
                valid_d[tail_q] = 1'b1;
                ready_d[tail_q] = 1'b0;
                dest_d[tail_q]  = alloc_dest_reg;
`ifdef ROB_EXC_EN
                exc_d[tail_q]   = 1'b0;
`endif
                tail_d          = tail_q + TAG_W'(1);
            end
            count_d = count_q + CNT_W'(alloc_accept) - CNT_W'(k);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q        <= '0;
            ready_q        <= '0;
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            commit_valid_q <= '0;
            commit_reg_q   <= '0;
            commit_value_q <= '0;
`ifdef ROB_EXC_EN
            exc_q          <= '0;
            exc_valid_q    <= 1'b0;
            exc_tag_q      <= '0;
`endif
        end else begin
            valid_q        <= valid_d;
            ready_q        <= ready_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            commit_valid_q <= commit_valid_d;
            commit_reg_q   <= commit_reg_d;
            commit_value_q <= commit_value_d;
`ifdef ROB_EXC_EN
            exc_q          <= exc_d;
            exc_valid_q    <= exc_valid_d;
            exc_tag_q      <= exc_tag_d;
`endif
        end
    end

    // Payload storage is qualified by valid/ready, so it needs no reset
    always_ff @(posedge clk) begin
        dest_q  <= dest_d;
        value_q <= value_d;
    end

endmodule
